// File: rtl/deser_rr_collector.sv
// deser_rr_collector: round-robin collector that shares one tagged byte FIFO
// between N_CH deserializer channels. Each channel gets a level acknowledge
// held until it drops data_ready; the FIFO head is offered on valid/ready.
module deser_rr_collector #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(N_CH),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clock_100KHZ,
  input  logic              reset,
  input  logic [N_CH-1:0]   ch_ready,
  input  logic [8*N_CH-1:0] ch_data,
  output logic [N_CH-1:0]   ch_ack,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [CW-1:0]     out_chan,
  input  logic              out_ready,
  output logic [AW:0]       fifo_count,
  output logic              fifo_full
);

  typedef enum logic {C_IDLE, C_ACK} ch_state_t;

  ch_state_t        state [N_CH];
  logic [CW-1:0]    rr_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW+7:0]    mem [DEPTH];

  logic [N_CH-1:0]  eligible;
  logic             grant_vld;
  logic [CW-1:0]    grant_idx;
  logic             full;
  logic             push;
  logic             pop;
  logic [CW+7:0]    push_word;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count_next;
  logic [CW+7:0]    head_word;

  // Channel index base+off, wrapping at N_CH-1 -> 0.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N_CH;
    return CW'(s);
  endfunction

  assign full       = (count == (AW+1)'(DEPTH));
  assign fifo_count = count;
  assign fifo_full  = full;

  // A channel may be granted only when idle, ready, and the FIFO has room.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      eligible[i] = (state[i] == C_IDLE) && ch_ready[i] && !full;
    end
  end

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!grant_vld && eligible[wrap_add(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  // FIFO control and the next head word for the registered output stage.
  // The new head is the word being pushed when the read pointer lands on the
  // write slot (empty FIFO, or last entry popped alongside a push).
  always_comb begin
    push       = grant_vld;
    pop        = out_valid && out_ready;
    push_word  = {grant_idx, ch_data[8*grant_idx +: 8]};
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    head_word  = (push && (rd_next == wr_ptr)) ? push_word : mem[rd_next];
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clock_100KHZ) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and registered head outputs.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        {out_chan, out_data} <= head_word;
      end
    end
  end

  // Round-robin pointer moves just past the granted channel.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Per-channel ack FSMs: ack rises on grant, falls once data_ready is low.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      ch_ack <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i] <= C_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        case (state[i])
          C_IDLE: begin
            if (grant_vld && (grant_idx == CW'(i))) begin
              state[i]  <= C_ACK;
              ch_ack[i] <= 1'b1;
            end
          end
          C_ACK: begin
            if (!ch_ready[i]) begin
              state[i]  <= C_IDLE;
              ch_ack[i] <= 1'b0;
            end
          end
          default: begin
            state[i]  <= C_IDLE;
            ch_ack[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
